// File: rtl/hamming_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hamming_link_ctrl
// Purpose  : Sequencing controller for a Hamming(16,11) link. It accepts one
//            11-bit word per handshake and drives it through the external
//            registered encoder. It forms the channel word, with an optional
//            single injected bit error, and drives the external registered
//            decoder. It then compares the recovered word with the original
//            and presents the result. Word and mismatch counters saturate.
// Option   : HAMMING_ERR_INJECT_EN - when defined, err_en/err_pos flip one
//            channel-word bit. When undefined, the channel word is the
//            encoder output unchanged.
// Ports    : clk, rst_n          clock, async active-low reset
//            in_valid/in_ready   source handshake, in_data[10:0]
//            err_en, err_pos     error injection control (sampled at accept)
//            enc_data_o          data to the encoder
//            enc_code_i          codeword from the encoder
//            dec_word_o          channel word to the decoder
//            dec_data_i          data from the decoder
//            out_valid/out_ready result handshake, out_data, out_mismatch
//            word_cnt, err_cnt   saturating statistics counters
//            busy                controller is not idle
// Revision : 1.0 - initial release
// ============================================================================
module hamming_link_ctrl #(
    parameter int ENC_LAT = 1,
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    input  logic             err_en,
    input  logic [3:0]       err_pos,
    output logic [10:0]      enc_data_o,
    input  logic [15:0]      enc_code_i,
    output logic [15:0]      dec_word_o,
    input  logic [10:0]      dec_data_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    // The wait counter runs 0..LAT-1 in ENC and in DEC.
    localparam int MAX_LAT = (ENC_LAT > DEC_LAT) ? ENC_LAT : DEC_LAT;
    localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [WAIT_W-1:0] ENC_LAST = WAIT_W'(ENC_LAT - 1);
    localparam logic [WAIT_W-1:0] DEC_LAST = WAIT_W'(DEC_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DEC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [WAIT_W-1:0] wait_q,     wait_d;
    logic [10:0]       enc_data_q, enc_data_d;
    logic [15:0]       dec_word_q, dec_word_d;
    logic [10:0]       out_data_q, out_data_d;
    logic              mism_q,     mism_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;
    logic [15:0]       w_err_mask;

`ifdef HAMMING_ERR_INJECT_EN
    logic       err_en_q,  err_en_d;
    logic [3:0] err_pos_q, err_pos_d;

    assign w_err_mask = err_en_q ? (16'd1 << err_pos_q) : 16'd0;
`else
    // Injection inputs have no function in this build.
    logic w_unused_err_inputs;
    assign w_unused_err_inputs = ^{err_en, err_pos};
    assign w_err_mask          = 16'd0;
`endif

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        enc_data_d = enc_data_q;
        dec_word_d = dec_word_q;
        out_data_d = out_data_q;
        mism_d     = mism_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
`ifdef HAMMING_ERR_INJECT_EN
        err_en_d   = err_en_q;
        err_pos_d  = err_pos_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    enc_data_d = in_data;
`ifdef HAMMING_ERR_INJECT_EN
                    err_en_d   = err_en;
                    err_pos_d  = err_pos;
`endif
                    wait_d     = '0;
                    state_d    = S_ENC;
                end
            end
            S_ENC: begin
                if (wait_q == ENC_LAST) begin
                    dec_word_d = enc_code_i ^ w_err_mask;
                    wait_d     = '0;
                    state_d    = S_DEC;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DEC: begin
                if (wait_q == DEC_LAST) begin
                    // enc_data_q still holds the accepted word at this point.
                    out_data_d = dec_data_i;
                    mism_d     = (dec_data_i != enc_data_q);
                    state_d    = S_OUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (word_cnt_q != CNT_MAX) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    if (mism_q && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            enc_data_q <= '0;
            dec_word_q <= '0;
            out_data_q <= '0;
            mism_q     <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
`ifdef HAMMING_ERR_INJECT_EN
            err_en_q   <= 1'b0;
            err_pos_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            enc_data_q <= enc_data_d;
            dec_word_q <= dec_word_d;
            out_data_q <= out_data_d;
            mism_q     <= mism_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
`ifdef HAMMING_ERR_INJECT_EN
            err_en_q   <= err_en_d;
            err_pos_q  <= err_pos_d;
`endif
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (state_q == S_OUT);
    assign enc_data_o   = enc_data_q;
    assign dec_word_o   = dec_word_q;
    assign out_data     = out_data_q;
    assign out_mismatch = mism_q;
    assign word_cnt     = word_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire
